// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem request handshake and IF/ID register; 1 cycle from imem_ack to ifid_ir.
// Hazard-unit stalls park an accepted word in a hold buffer; a redirect while a fetch is outstanding drains the stale response.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        reg_en,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_ir,
  output logic [31:0] ifid_pc,
  output logic        ifid_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ipc_q, ipc_d;
  logic        vld_q, vld_d;
  logic [31:0] hold_ir_q, hold_ir_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;

  logic        advance;
  logic [31:0] br_pc;
  logic        unused_tgt_lsbs;

  assign advance         = reg_en & pc_write;
  assign br_pc           = {br_target[31:2], 2'b00};
  assign unused_tgt_lsbs = ^br_target[1:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    ipc_d        = ipc_q;
    vld_d        = vld_q;
    hold_ir_d    = hold_ir_q;
    hold_pc_d    = hold_pc_q;
    drain_addr_d = drain_addr_q;

    if (br_taken) begin
      // Redirect overrides stalls; IF/ID keeps its old pc so the bubble stays traceable.
      pc_d      = br_pc;
      ir_d      = NOP_INSTR;
      vld_d     = 1'b0;
      hold_ir_d = '0;
      hold_pc_d = '0;
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            state_d = S_FETCH;
          end else begin
            state_d      = S_DRAIN;
            drain_addr_d = pc_q;
          end
        end
        S_DRAIN: state_d = imem_ack ? S_FETCH : S_DRAIN;
        default: state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            if (advance) begin
              ir_d  = imem_rdata;
              ipc_d = pc_q;
              vld_d = 1'b1;
              pc_d  = pc_q + 32'd4;
            end else begin
              hold_ir_d = imem_rdata;
              hold_pc_d = pc_q;
              state_d   = S_HOLD;
            end
          end else if (reg_en) begin
            ir_d  = NOP_INSTR;
            ipc_d = pc_q;
            vld_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (advance) begin
            ir_d    = hold_ir_q;
            ipc_d   = hold_pc_q;
            vld_d   = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_ack) state_d = S_FETCH;
          if (reg_en) begin
            ir_d  = NOP_INSTR;
            ipc_d = pc_q;
            vld_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= NOP_INSTR;
      ipc_q        <= RESET_PC;
      vld_q        <= 1'b0;
      hold_ir_q    <= '0;
      hold_pc_q    <= '0;
      drain_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ipc_q        <= ipc_d;
      vld_q        <= vld_d;
      hold_ir_q    <= hold_ir_d;
      hold_pc_q    <= hold_pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  // The stale address is kept on the bus while draining so the memory sees a stable request.
  assign imem_req   = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem_addr  = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign ifid_ir    = ir_q;
  assign ifid_pc    = ipc_q;
  assign ifid_valid = vld_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a latency-configurable instruction memory plus a transaction-level reference model.
module tb_fetch_stage;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_write = 1'b0, reg_en = 1'b0, br_taken = 1'b0, imem_ack = 1'b0;
  logic [31:0] br_target = '0, imem_rdata = '0;
  logic        imem_req, ifid_valid;
  logic [31:0] imem_addr, ifid_ir, ifid_pc;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .reg_en(reg_en),
    .br_taken(br_taken), .br_target(br_target), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ifid_ir(ifid_ir), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid)
  );

  int n_vec = 0, n_err = 0;

  // Reference model: "started", "holding a word", "discarding an old response".
  bit          m_idle, m_held, m_drain, m_vld;
  logic [31:0] m_pc, m_ir, m_ipc, m_hir, m_hpc, m_daddr;

  int mem_lat = 0;
  int lat_cnt = 0;
  bit spurious = 1'b0;
  bit force_ack = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic int next_lat();
    return (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 2));
  endfunction

  function automatic bit exp_req();
    return !m_idle && !m_held;
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_drain ? m_daddr : m_pc;
  endfunction

  task automatic model_reset();
    m_idle = 1; m_held = 0; m_drain = 0; m_vld = 0;
    m_pc = RPC; m_ir = NOP; m_ipc = RPC; m_hir = '0; m_hpc = '0; m_daddr = RPC;
  endtask

  // Called at a negedge: memory answers, inputs are driven, model advances, one clock elapses.
  task automatic run_cycle(input bit br, input logic [31:0] tgt, input bit re, input bit pw);
    logic        ack;
    logic [31:0] rd;
    logic [31:0] cur;
    if (imem_req) begin
      if (lat_cnt == 0) begin
        ack = 1'b1; rd = mem_word(imem_addr); lat_cnt = next_lat();
      end else begin
        ack = 1'b0; rd = $urandom; lat_cnt--;
      end
    end else begin
      ack = force_ack || (spurious && ($urandom_range(0, 3) == 0));
      rd = $urandom; lat_cnt = next_lat();
    end
    br_taken = br; br_target = tgt; reg_en = re; pc_write = pw;
    imem_ack = ack; imem_rdata = rd;

    cur = exp_addr();
    if (m_idle) begin
      if (br) begin m_pc = tgt & ~32'h3; m_ir = NOP; m_vld = 0; end
      m_idle = 0;
    end else if (br) begin
      if (!m_held) begin
        if (ack) m_drain = 0;
        else begin m_drain = 1; m_daddr = cur; end
      end
      m_held = 0;
      m_pc = tgt & ~32'h3; m_ir = NOP; m_vld = 0;
    end else if (m_held) begin
      if (re && pw) begin
        m_ir = m_hir; m_ipc = m_hpc; m_vld = 1; m_pc = m_pc + 32'd4; m_held = 0;
      end
    end else if (m_drain) begin
      if (ack) m_drain = 0;
      if (re) begin m_ir = NOP; m_ipc = m_pc; m_vld = 0; end
    end else if (ack) begin
      if (re && pw) begin
        m_ir = rd; m_ipc = m_pc; m_vld = 1; m_pc = m_pc + 32'd4;
      end else begin
        m_held = 1; m_hir = rd; m_hpc = m_pc;
      end
    end else if (re) begin
      m_ir = NOP; m_ipc = m_pc; m_vld = 0;
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_vec++; if (ifid_ir !== NOP) begin n_err++; $display("FAIL reset_ir: got %h expected %h", ifid_ir, NOP); end
    n_vec++; if (ifid_pc !== RPC) begin n_err++; $display("FAIL reset_pc: got %h expected %h", ifid_pc, RPC); end
    n_vec++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", ifid_valid); end
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_vec++; if (imem_addr !== RPC) begin n_err++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RPC); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    force_ack = 1'b1;
    run_cycle(0, '0, 1, 1);
    force_ack = 1'b0;
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b expected 1", imem_req); end
    n_vec++; if (imem_addr !== RPC) begin n_err++; $display("FAIL first_addr: got %h expected %h", imem_addr, RPC); end
    n_vec++; if (ifid_valid !== 1'b0 || ifid_ir !== NOP) begin
      n_err++; $display("FAIL idle_ack_ignored: got valid=%b ir=%h expected valid=0 ir=%h", ifid_valid, ifid_ir, NOP);
    end
  endtask

  task automatic test_stream();
    mem_lat = 0; lat_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      run_cycle(0, '0, 1, 1);
      n_vec++; if (ifid_pc !== 32'(4 * i) || ifid_valid !== 1'b1) begin
        n_err++; $display("FAIL stream_ifid[%0d]: got pc=%h v=%b expected pc=%h v=1", i, ifid_pc, ifid_valid, 32'(4 * i));
      end
      n_vec++; if (ifid_ir !== mem_word(32'(4 * i))) begin
        n_err++; $display("FAIL stream_ir[%0d]: got %h expected %h", i, ifid_ir, mem_word(32'(4 * i)));
      end
      n_vec++; if (imem_addr !== 32'(4 * (i + 1))) begin
        n_err++; $display("FAIL stream_addr[%0d]: got %h expected %h", i, imem_addr, 32'(4 * (i + 1)));
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, '0, 0, 0);
      n_vec++; if (ifid_pc !== 32'h0C || ifid_valid !== 1'b1 || imem_req !== 1'b0) begin
        n_err++; $display("FAIL hold[%0d]: got pc=%h v=%b req=%b expected pc=0000000c v=1 req=0", i, ifid_pc, ifid_valid, imem_req);
      end
    end
    run_cycle(0, '0, 1, 1);
    n_vec++; if (ifid_pc !== 32'h10 || ifid_ir !== mem_word(32'h10) || ifid_valid !== 1'b1) begin
      n_err++; $display("FAIL hold_release: got pc=%h ir=%h v=%b expected pc=00000010 ir=%h v=1", ifid_pc, ifid_ir, ifid_valid, mem_word(32'h10));
    end
    n_vec++; if (imem_addr !== 32'h14 || imem_req !== 1'b1) begin
      n_err++; $display("FAIL hold_next_addr: got %h req=%b expected 00000014 req=1", imem_addr, imem_req);
    end
  endtask

  task automatic test_branch_wait();
    mem_lat = 2; lat_cnt = 2;
    run_cycle(0, '0, 1, 1);
    run_cycle(1, 32'h203, 1, 1);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      n_err++; $display("FAIL drain_addr: got %h req=%b expected 00000014 req=1", imem_addr, imem_req);
    end
    n_vec++; if (ifid_valid !== 1'b0 || ifid_ir !== NOP) begin
      n_err++; $display("FAIL drain_flush: got v=%b ir=%h expected v=0 ir=%h", ifid_valid, ifid_ir, NOP);
    end
    run_cycle(0, '0, 1, 1);
    n_vec++; if (imem_addr !== 32'h200 || ifid_valid !== 1'b0 || ifid_ir !== NOP) begin
      n_err++; $display("FAIL drain_discard: got addr=%h v=%b ir=%h expected addr=00000200 v=0 ir=%h", imem_addr, ifid_valid, ifid_ir, NOP);
    end
    mem_lat = 0; lat_cnt = 0;
    run_cycle(0, '0, 1, 1);
    n_vec++; if (ifid_pc !== 32'h200 || ifid_ir !== mem_word(32'h200) || imem_addr !== 32'h204) begin
      n_err++; $display("FAIL target_fetch: got pc=%h ir=%h addr=%h expected pc=00000200 ir=%h addr=00000204", ifid_pc, ifid_ir, imem_addr, mem_word(32'h200));
    end
  endtask

  task automatic test_branch_stall();
    run_cycle(1, 32'h1000, 0, 0);
    n_vec++; if (ifid_ir !== NOP || ifid_valid !== 1'b0 || ifid_pc !== 32'h200) begin
      n_err++; $display("FAIL flush_on_stall: got ir=%h v=%b pc=%h expected ir=%h v=0 pc=00000200", ifid_ir, ifid_valid, ifid_pc, NOP);
    end
    n_vec++; if (imem_addr !== 32'h1000 || imem_req !== 1'b1) begin
      n_err++; $display("FAIL flush_target: got %h req=%b expected 00001000 req=1", imem_addr, imem_req);
    end
  endtask

  task automatic test_wrap();
    run_cycle(1, 32'hFFFF_FFFE, 1, 1);
    n_vec++; if (imem_addr !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL wrap_target: got %h expected fffffffc", imem_addr);
    end
    run_cycle(0, '0, 1, 1);
    n_vec++; if (imem_addr !== 32'h0 || ifid_pc !== 32'hFFFF_FFFC || ifid_valid !== 1'b1) begin
      n_err++; $display("FAIL wrap_next: got addr=%h pc=%h v=%b expected addr=00000000 pc=fffffffc v=1", imem_addr, ifid_pc, ifid_valid);
    end
  endtask

  task automatic test_async_reset();
    run_cycle(0, '0, 0, 0);
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL pre_reset_hold: got req=%b expected 0", imem_req); end
    imem_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (ifid_ir !== NOP || ifid_pc !== RPC || ifid_valid !== 1'b0) begin
      n_err++; $display("FAIL async_ifid: got ir=%h pc=%h v=%b expected ir=%h pc=%h v=0", ifid_ir, ifid_pc, ifid_valid, NOP, RPC);
    end
    n_vec++; if (imem_req !== 1'b0 || imem_addr !== RPC) begin
      n_err++; $display("FAIL async_imem: got req=%b addr=%h expected req=0 addr=%h", imem_req, imem_addr, RPC);
    end
    model_reset();
    lat_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle(0, '0, 1, 1);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin
      n_err++; $display("FAIL restart_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RPC);
    end
    run_cycle(0, '0, 1, 1);
    n_vec++; if (ifid_pc !== RPC || ifid_valid !== 1'b1 || imem_addr !== RPC + 32'd4) begin
      n_err++; $display("FAIL restart_fetch: got pc=%h v=%b addr=%h expected pc=%h v=1 addr=%h", ifid_pc, ifid_valid, imem_addr, RPC, RPC + 32'd4);
    end
  endtask

  task automatic test_random();
    bit          br, re, pw;
    logic [31:0] tgt;
    mem_lat = -1; spurious = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      br  = ($urandom_range(0, 7) == 0);
      tgt = $urandom;
      re  = ($urandom_range(0, 3) != 0);
      pw  = ($urandom_range(0, 4) != 0);
      run_cycle(br, tgt, re, pw);
      n_vec++; if (ifid_ir !== m_ir || ifid_pc !== m_ipc || ifid_valid !== m_vld) begin
        n_err++; $display("FAIL rand_ifid[%0d]: got ir=%h pc=%h v=%b expected ir=%h pc=%h v=%b", i, ifid_ir, ifid_pc, ifid_valid, m_ir, m_ipc, m_vld);
      end
      n_vec++; if (imem_req !== exp_req()) begin
        n_err++; $display("FAIL rand_req[%0d]: got %b expected %b", i, imem_req, exp_req());
      end
      if (exp_req()) begin
        n_vec++; if (imem_addr !== exp_addr()) begin
          n_err++; $display("FAIL rand_addr[%0d]: got %h expected %h", i, imem_addr, exp_addr());
        end
      end
    end
    spurious = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_branch_wait();
    test_branch_stall();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
